// File: rtl/io_pkg.sv
// Shared address map for the CPU memory-mapped I/O ports.
// The output-port decoder uses the same base so the two maps stay consistent.
package io_pkg;

  localparam logic [31:0] IO_BASE_ADDR = 32'h0000_0080;

  localparam logic [31:0] IO_OFS_SW  = 32'h0;
  localparam logic [31:0] IO_OFS_KEY = 32'h4;
  localparam logic [31:0] IO_OFS_EVT = 32'h8;

  localparam logic [31:0] IO_WINDOW_BYTES = 32'd12;

  typedef enum logic [1:0] {
    REG_SW  = 2'd0,
    REG_KEY = 2'd1,
    REG_EVT = 2'd2,
    REG_NONE = 2'd3
  } io_reg_e;

  // Byte offset to register word; low two address bits are ignored.
  function automatic io_reg_e io_reg_of(input logic [31:0] ofs);
    return io_reg_e'(ofs[3:2]);
  endfunction

endpackage

// File: rtl/io_input_port_if.sv
// CPU data-memory side bus of the input port.
// The CPU drives address/store data; the port returns hit and read data.
interface io_input_port_if;

  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wmem;
  logic        hit;
  logic [31:0] rdata;

  modport master (
    output addr,
    output wdata,
    output wmem,
    input  hit,
    input  rdata
  );

  modport slave (
    input  addr,
    input  wdata,
    input  wmem,
    output hit,
    output rdata
  );

endinterface

// File: rtl/io_debounce.sv
// Per-key two-flop synchroniser and counting debouncer.
// rise is high in the cycle whose edge takes lvl from 0 to 1.
module io_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic lvl,
  output logic rise
);

  localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [1:0]  sync;
  logic [15:0] cnt;
  logic        pressed_s;
  logic        done;

  // Inverted before the flops so a reset synchroniser reads as released.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[0], ~key_n};
    end
  end

  assign pressed_s = sync[1];
  assign done      = (pressed_s != lvl) && (cnt == LAST);
  assign rise      = done && pressed_s;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
      lvl <= 1'b0;
    end else if (pressed_s == lvl) begin
      cnt <= '0;
    end else if (done) begin
      cnt <= '0;
      lvl <= pressed_s;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/io_input_port.sv
// Memory-mapped switch/key input port on the CPU data-memory read path.
// Switches are synchronised; keys are debounced and latched as W1C events.
module io_input_port
  import io_pkg::*;
#(
  parameter int unsigned SW_WIDTH        = 10,
  parameter int unsigned KEY_WIDTH       = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter logic [31:0] BASE_ADDR       = IO_BASE_ADDR
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [SW_WIDTH-1:0]  sw,
  input  logic [KEY_WIDTH-1:0] key_n,
  io_input_port_if.slave       bus,
  output logic [KEY_WIDTH-1:0] key_level,
  output logic [KEY_WIDTH-1:0] key_event
);

  logic [SW_WIDTH-1:0]  sw_s1;
  logic [SW_WIDTH-1:0]  sw_s2;
  logic [SW_WIDTH-1:0]  sw_reg;
  logic [KEY_WIDTH-1:0] rise;
  logic [KEY_WIDTH-1:0] clr_mask;
  logic [7:0]           press_cnt;
  logic [31:0]          ofs;
  logic [31:0]          rd;
  io_reg_e              reg_sel;
  logic                 hit;
  logic                 sel_sw;
  logic                 sel_key;
  logic                 sel_evt;
  logic                 unused;

  assign ofs     = bus.addr - BASE_ADDR;
  assign hit     = ofs < IO_WINDOW_BYTES;
  assign reg_sel = io_reg_of(ofs);

  assign sel_sw  = hit && (reg_sel == io_reg_of(IO_OFS_SW));
  assign sel_key = hit && (reg_sel == io_reg_of(IO_OFS_KEY));
  assign sel_evt = hit && (reg_sel == io_reg_of(IO_OFS_EVT));

  assign clr_mask = (bus.wmem && sel_evt)
                  ? bus.wdata[KEY_WIDTH-1:0] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      sw_reg <= '0;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      sw_reg <= sw_s2;
    end
  end

  for (genvar i = 0; i < KEY_WIDTH; i++) begin : g_key
    io_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clock(clock),
      .reset(reset),
      .key_n(key_n[i]),
      .lvl  (key_level[i]),
      .rise (rise[i])
    );
  end

  // A new press in the same cycle as its clear leaves the flag set.
  always_ff @(posedge clock) begin
    if (reset) begin
      key_event <= '0;
      press_cnt <= '0;
    end else begin
      key_event <= (key_event & ~clr_mask) | rise;
      if (|rise) begin
        press_cnt <= press_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    rd = '0;
    unique case (1'b1)
      sel_sw: rd[SW_WIDTH-1:0] = sw_reg;
      sel_key: rd[KEY_WIDTH-1:0] = key_level;
      sel_evt: begin
        rd[15:8]          = press_cnt;
        rd[KEY_WIDTH-1:0] = key_event;
      end
      default: rd = '0;
    endcase
  end

  assign bus.hit   = hit;
  assign bus.rdata = rd;

  assign unused = ^{bus.wdata[31:KEY_WIDTH], ofs[1:0]};

endmodule

// File: doc/io_input_port.md
Name: io_input_port

Overview:
- Memory-mapped input peripheral for the single-cycle CPU system. It is the read-side counterpart of the CPU's output port.
- Samples board switches and push-keys, synchronises and debounces them, and latches key-press events as sticky status bits.
- Presents all of this as read-only words on the CPU data-memory read path, selected by address.
- Sits beside data memory in the CPU main block. The top level muxes this block's `rdata` onto `memout` when `hit`=1.

Parameters:
- SW_WIDTH, 10, number of slide switches.
- KEY_WIDTH, 4, number of push keys (board keys are active-low).
- DEBOUNCE_CYCLES, 20000, number of consecutive stable samples required before a key level is accepted. Minimum is 2; the bench uses 4.
- BASE_ADDR, 32'h0000_0080, word-aligned base address of the register window.

Ports:
- clock  input  1  system clock (the CPU clock domain).
- reset  input  1  synchronous, active-high reset.
- sw  input  SW_WIDTH  raw switch levels, asynchronous to `clock`.
- key_n  input  KEY_WIDTH  raw active-low key levels, asynchronous and bouncing.
- addr  input  32  CPU byte address (the ALU result).
- wdata  input  32  CPU store data.
- wmem  input  1  CPU store strobe, sampled on the rising edge of `clock`.
- hit  output  1  1 when `addr` falls within [BASE_ADDR, BASE_ADDR+0xC); combinational.
- rdata  output  32  read data for `addr`; combinational from internal registers.
- key_level  output  KEY_WIDTH  debounced pressed level, active-high.
- key_event  output  KEY_WIDTH  sticky press flags, also readable at offset 0x8.

Behaviour:
- Synchroniser: two-flop synchroniser on every `sw` and `key_n` bit. Synchronised key value is `pressed_s = ~key_n_sync`.
- Switch register:
  - `sw_reg` loads the synchronised `sw` every cycle.
  - Total latency from a `sw` change to `rdata` at offset 0x0 is 3 clock edges.
- Debounce, per key, 16-bit counter `cnt` and stable bit `lvl`:
  - If `pressed_s` == `lvl`: `cnt` <= 0.
  - Otherwise: `cnt` <= `cnt`+1. When `cnt` == DEBOUNCE_CYCLES-1, `lvl` <= `pressed_s` and `cnt` <= 0.
  - Any mismatch gap restarts the count from 0, so bounces shorter than DEBOUNCE_CYCLES never change `lvl`.
  - Latency from a clean edge to a `lvl` change is 2+DEBOUNCE_CYCLES cycles.
- Events:
  - A `lvl` rising edge (0->1) sets `key_event[i]`.
  - A release sets nothing.
- Clear: a store with `wmem`=1 and `addr`=BASE_ADDR+0x8 clears `key_event` bits where `wdata[i]`=1 (write-1-to-clear).
  - Clear and set on the same cycle for the same bit: set wins, bit ends at 1.
  - Stores to offsets 0x0 and 0x4 are ignored.
- Press counter `press_cnt`, 8-bit: increments on each cycle where at least one key has a rising `lvl` edge (once per cycle, not once per key). Wraps 0xFF->0x00.
- Read map (offset = `addr` - BASE_ADDR; `addr[1:0]` ignored; unused bits read 0):
  - 0x0: {0, sw_reg}.
  - 0x4: {0, key_level}.
  - 0x8: {0, press_cnt[7:0], 0.., key_event}, with `press_cnt` in bits [15:8] and `key_event` in [KEY_WIDTH-1:0].
- Out of range: when `hit`=0, `rdata`=0.
- Reading has no side effects.
- Reset, synchronous and active-high, applies on any cycle including mid-debounce: synchronisers, `sw_reg`, `cnt`, `lvl`, `key_event`, `press_cnt` all go to 0. After release the block restarts cleanly.

Decomposition:
- Shared package `io_pkg` holds:
  - Register offsets: IO_OFS_SW=0x0, IO_OFS_KEY=0x4, IO_OFS_EVT=0x8.
  - IO_WINDOW_BYTES=12.
  - Default BASE_ADDR, shared with the output-port decoder so the two address maps stay consistent.
- One sub-module, `io_debounce`, instantiated once per key: synchroniser, counter and `lvl`, plus a one-cycle `rise` pulse output.
- Switch synchronisers stay inline in the top module.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: assert `reset` 2 cycles with `sw`=0x3FF -> `rdata`@0x0=0 and `key_event`=0 during reset; `rdata`@0x0=0x3FF on the 3rd edge after release.
- Clean press: `key_n`=4'b1110 held -> `key_level`=0x1 exactly 6 cycles later, `key_event`=0x1, `rdata`@0x8=0x0000_0101.
- Bounce: `key_n[1]` toggles every 2 cycles for 20 cycles, then returns high -> `key_level`, `key_event` and `press_cnt` remain 0.
- W1C race: store `wdata`=0x1 to 0x88 on the same cycle key0 rises again -> `key_event[0]`=1. A store with `wdata`=0x1 one cycle later clears it -> `rdata`@0x8 bits [3:0]=0.
- Wrap: 256 separate presses of key2 -> `press_cnt`=0x00, `key_event[2]`=1.
- Decode: `addr`=0x7C and `addr`=0x8C -> `hit`=0, `rdata`=0. `addr`=0x86 -> same data as 0x84. Store to 0x80 leaves `sw_reg` unchanged.
